// File: rtl/tbus_master.sv
// ---------------------------------------------------------------------------
// tbus_master
//   Bus initiator for the tagged 64-bit multiplexed address/data memory bus.
//   Non-CPU agents issue read, write and atomic swap requests through a
//   valid/ready port. Requests are queued in a small FIFO and executed in
//   order. Read data (read, and the old value of a swap) comes back as a
//   one-cycle pulse on the response port.
//
//   Parameters
//     FIFO_DEPTH : request FIFO entries (power of two, >= 2)
//     AW         : word-address width, drives o_ad[AW-1:0]
//
//   Ports
//     clk, reset           : clock (rising edge), synchronous active-low reset
//     req_valid/req_ready  : request handshake (ready = FIFO not full)
//     req_op               : 00 read, 01 write, 10 swap, 11 reserved (dropped)
//     req_addr/data/tag    : request word address, write data and tag
//     rsp_valid/data/tag   : one-cycle response pulse with read data and tag
//     busy                 : FIFO non-empty or a transaction in flight
//     o_ad, o_tag          : multiplexed address/data and tag to memory
//     o_astb, o_rd, o_wr   : address, read and write strobes
//     o_atomic             : read-modify-write flag for swaps
//     i_data, i_tag        : memory read data/tag, valid one cycle after o_rd
//
//   Optional build macro TBUS_MASTER_STATS_EN adds stat_rd, stat_wr and
//   stat_swap operation counters.
// ---------------------------------------------------------------------------
module tbus_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [63:0]   req_data,
    input  logic [7:0]    req_tag,
    output logic          rsp_valid,
    output logic [63:0]   rsp_data,
    output logic [7:0]    rsp_tag,
    output logic          busy,
    output logic [63:0]   o_ad,
    output logic [7:0]    o_tag,
    output logic          o_astb,
    output logic          o_atomic,
    output logic          o_rd,
    output logic          o_wr,
    input  logic [63:0]   i_data,
    input  logic [7:0]    i_tag
`ifdef TBUS_MASTER_STATS_EN
    ,
    output logic [31:0]   stat_rd,
    output logic [31:0]   stat_wr,
    output logic [31:0]   stat_swap
`endif
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int PTRW = PW + 1;

    typedef enum logic [2:0] {IDLE, ADDR, RD, RCAP, WR} state_e;
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SWAP  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    // Request FIFO storage (no reset needed: guarded by the pointers)
    logic [1:0]    fifo_op_mem   [FIFO_DEPTH];
    logic [AW-1:0] fifo_addr_mem [FIFO_DEPTH];
    logic [63:0]   fifo_data_mem [FIFO_DEPTH];
    logic [7:0]    fifo_tag_mem  [FIFO_DEPTH];

    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [63:0]     data_q, data_d;
    logic [7:0]      tag_q, tag_d;

    logic            req_ready_q, req_ready_d;
    logic            busy_q, busy_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [63:0]     rsp_data_q, rsp_data_d;
    logic [7:0]      rsp_tag_q, rsp_tag_d;
    logic [63:0]     o_ad_q, o_ad_d;
    logic [7:0]      o_tag_q, o_tag_d;
    logic            o_astb_q, o_astb_d;
    logic            o_atomic_q, o_atomic_d;
    logic            o_rd_q, o_rd_d;
    logic            o_wr_q, o_wr_d;

    logic push, pop, empty, full_d;
    op_e  head_op;

    assign push    = req_valid && req_ready_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign pop     = (state_q == IDLE) && !empty;
    assign head_op = op_e'(fifo_op_mem[rd_ptr_q[PW-1:0]]);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op_mem[wr_ptr_q[PW-1:0]]   <= req_op;
            fifo_addr_mem[wr_ptr_q[PW-1:0]] <= req_addr;
            fifo_data_mem[wr_ptr_q[PW-1:0]] <= req_data;
            fifo_tag_mem[wr_ptr_q[PW-1:0]]  <= req_tag;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTRW'(push);
        rd_ptr_d = rd_ptr_q + PTRW'(pop);
        full_d   = (wr_ptr_d[PW] != rd_ptr_d[PW]) &&
                   (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]);

        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        tag_d   = tag_q;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    op_d   = head_op;
                    addr_d = fifo_addr_mem[rd_ptr_q[PW-1:0]];
                    data_d = fifo_data_mem[rd_ptr_q[PW-1:0]];
                    tag_d  = fifo_tag_mem[rd_ptr_q[PW-1:0]];
                    // Reserved ops are consumed here and never reach the bus
                    if (head_op != OP_RSVD) state_d = ADDR;
                end
            end
            ADDR:    state_d = (op_q == OP_WRITE) ? WR : RD;
            RD:      state_d = RCAP;
            RCAP:    state_d = (op_q == OP_SWAP) ? WR : IDLE;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered: decode them from the state being entered
        req_ready_d = !full_d;
        busy_d      = (wr_ptr_d != rd_ptr_d) || (state_d != IDLE);
        o_astb_d    = (state_d == ADDR);
        o_rd_d      = (state_d == RD);
        o_wr_d      = (state_d == WR);
        o_atomic_d  = (state_d != IDLE) && (op_d == OP_SWAP);
        o_ad_d      = '0;
        o_tag_d     = '0;
        if (state_d == ADDR) begin
            o_ad_d = 64'(addr_d);
        end else if (state_d == WR) begin
            o_ad_d  = data_d;
            o_tag_d = tag_d;
        end

        // Memory data is valid during RCAP; it is presented the cycle after
        rsp_valid_d = (state_q == RCAP);
        rsp_data_d  = (state_q == RCAP) ? i_data : rsp_data_q;
        rsp_tag_d   = (state_q == RCAP) ? i_tag  : rsp_tag_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= IDLE;
            op_q        <= OP_READ;
            addr_q      <= '0;
            data_q      <= '0;
            tag_q       <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            o_ad_q      <= '0;
            o_tag_q     <= '0;
            o_astb_q    <= 1'b0;
            o_atomic_q  <= 1'b0;
            o_rd_q      <= 1'b0;
            o_wr_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            tag_q       <= tag_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            o_ad_q      <= o_ad_d;
            o_tag_q     <= o_tag_d;
            o_astb_q    <= o_astb_d;
            o_atomic_q  <= o_atomic_d;
            o_rd_q      <= o_rd_d;
            o_wr_q      <= o_wr_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign o_ad      = o_ad_q;
    assign o_tag     = o_tag_q;
    assign o_astb    = o_astb_q;
    assign o_atomic  = o_atomic_q;
    assign o_rd      = o_rd_q;
    assign o_wr      = o_wr_q;

`ifdef TBUS_MASTER_STATS_EN
    logic [31:0] stat_rd_q, stat_rd_d;
    logic [31:0] stat_wr_q, stat_wr_d;
    logic [31:0] stat_swap_q, stat_swap_d;

    // Each counter steps at the end of its operation's final strobe cycle
    always_comb begin
        stat_rd_d   = stat_rd_q   + 32'(state_q == RD && op_q == OP_READ);
        stat_wr_d   = stat_wr_q   + 32'(state_q == WR && op_q == OP_WRITE);
        stat_swap_d = stat_swap_q + 32'(state_q == WR && op_q == OP_SWAP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_rd_q   <= '0;
            stat_wr_q   <= '0;
            stat_swap_q <= '0;
        end else begin
            stat_rd_q   <= stat_rd_d;
            stat_wr_q   <= stat_wr_d;
            stat_swap_q <= stat_swap_d;
        end
    end

    assign stat_rd   = stat_rd_q;
    assign stat_wr   = stat_wr_q;
    assign stat_swap = stat_swap_q;
`endif

endmodule

// File: tb/tb_tbus_master.sv
module tb_tbus_master;

    localparam int AW    = 20;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = '0;
    logic [AW-1:0] req_addr = '0;
    logic [63:0]   req_data = '0;
    logic [7:0]    req_tag = '0;
    logic          rsp_valid;
    logic [63:0]   rsp_data;
    logic [7:0]    rsp_tag;
    logic          busy;
    logic [63:0]   o_ad;
    logic [7:0]    o_tag;
    logic          o_astb, o_atomic, o_rd, o_wr;
    logic [63:0]   i_data = '0;
    logic [7:0]    i_tag = '0;
`ifdef TBUS_MASTER_STATS_EN
    logic [31:0]   stat_rd, stat_wr, stat_swap;
`endif

    always #5 clk = ~clk;

    tbus_master #(.FIFO_DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .busy(busy), .o_ad(o_ad), .o_tag(o_tag), .o_astb(o_astb),
        .o_atomic(o_atomic), .o_rd(o_rd), .o_wr(o_wr),
        .i_data(i_data), .i_tag(i_tag)
`ifdef TBUS_MASTER_STATS_EN
        , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_swap(stat_swap)
`endif
    );

    // Environment memory: latches address on o_astb, returns data the cycle
    // after o_rd, stores {tag,data} on o_wr.
    logic [71:0] ram [256];
    logic [7:0]  ram_addr = '0;
    always @(posedge clk) begin
        if (o_astb) ram_addr <= o_ad[7:0];
        if (o_rd) {i_tag, i_data} <= ram[ram_addr];
        if (o_wr) ram[ram_addr] <= {o_tag, o_ad};
    end

    // Bus/response monitor
    int          cyc = 0, n_astb = 0, n_rd = 0, n_wr = 0, n_atomic = 0, n_viol = 0;
    int          astb_times[$];
    logic [71:0] rsp_q[$];
    always @(negedge clk) begin
        cyc++;
        if (o_astb) begin
            n_astb++;
            astb_times.push_back(cyc);
        end
        if (o_rd) n_rd++;
        if (o_wr) n_wr++;
        if (o_atomic) n_atomic++;
        if ((int'(o_astb) + int'(o_rd) + int'(o_wr)) > 1) n_viol++;
        if (rsp_valid) rsp_q.push_back({rsp_tag, rsp_data});
    end

    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [63:0] d, input logic [7:0] t);
        bit ok = 1'b0;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        req_tag   = t;
        for (int k = 0; k < 200; k++) begin
            if (req_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        req_valid = 1'b0;
        chk("push_accept", 72'(ok), 72'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [71:0] model [256];
    logic [71:0] exp_q[$];

    initial begin
        logic [1:0]    op;
        logic [AW-1:0] a;
        logic [63:0]   d;
        logic [7:0]    t;
        int            accepted, a_base, r_base, t_base, seen_low;
        int            s_astb, s_rd, s_wr, s_atomic, s_viol;
        int            n_read, n_write, n_swap, n_rsvd;
        int            cost[5];
        logic [71:0]   exp_rsp[3];

        for (int i = 0; i < 256; i++) begin
            ram[i]   = {$urandom, $urandom, $urandom};
            model[i] = ram[i];
        end

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_req_ready", 72'(req_ready), 72'd0);
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_strobes", 72'({o_astb, o_rd, o_wr, o_atomic, rsp_valid}), 72'd0);
        chk("rst_o_ad_tag", {o_tag, o_ad}, 72'd0);
        chk("rst_rsp", {rsp_tag, rsp_data}, 72'd0);
        reset = 1'b1;
        tick();
        chk("rst_ready_after", 72'(req_ready), 72'd1);

        // ---------------- directed write ----------------
        push(2'b01, 20'h00010, 64'h0123456789ABCDEF, 8'h35);
        tick();
        chk("wr_astb", 72'({o_astb, o_rd, o_wr, o_atomic}), 72'b1000);
        chk("wr_addr", {o_tag, o_ad}, 72'h00_0000000000000010);
        tick();
        chk("wr_strobe", 72'({o_astb, o_rd, o_wr, o_atomic}), 72'b0010);
        chk("wr_data", {o_tag, o_ad}, 72'h35_0123456789ABCDEF);
        tick();
        chk("wr_done", 72'({o_astb, o_rd, o_wr, busy}), 72'd0);
        chk("wr_ram", ram[8'h10], 72'h35_0123456789ABCDEF);

        // ---------------- directed read ----------------
        push(2'b00, 20'h00010, 64'h0, 8'h0);
        tick();
        chk("rd_astb", 72'({o_astb, o_rd, o_wr, o_atomic}), 72'b1000);
        chk("rd_addr", {o_tag, o_ad}, 72'h10);
        tick();
        chk("rd_strobe", 72'({o_astb, o_rd, o_wr, o_atomic}), 72'b0100);
        chk("rd_ad_zero", {o_tag, o_ad}, 72'd0);
        tick();
        chk("rd_rcap", 72'({o_astb, o_rd, o_wr, rsp_valid}), 72'd0);
        tick();
        chk("rd_rsp_valid", 72'(rsp_valid), 72'd1);
        chk("rd_rsp", {rsp_tag, rsp_data}, 72'h35_0123456789ABCDEF);
        tick();
        chk("rd_rsp_pulse", 72'(rsp_valid), 72'd0);

        // ---------------- directed swap ----------------
        push(2'b10, 20'h00010, 64'hFFFF0000FFFF0000, 8'h07);
        tick();
        chk("sw_c0", 72'({o_astb, o_rd, o_wr, o_atomic}), 72'b1001);
        tick();
        chk("sw_c1", 72'({o_astb, o_rd, o_wr, o_atomic}), 72'b0101);
        tick();
        chk("sw_c2", 72'({o_astb, o_rd, o_wr, o_atomic}), 72'b0001);
        tick();
        chk("sw_c3", 72'({o_astb, o_rd, o_wr, o_atomic}), 72'b0011);
        chk("sw_wdata", {o_tag, o_ad}, 72'h07_FFFF0000FFFF0000);
        chk("sw_rsp", {71'(0), rsp_valid, rsp_tag, rsp_data} >> 0 == 0 ? 72'd0 : {rsp_tag, rsp_data},
            72'h35_0123456789ABCDEF);
        chk("sw_rsp_valid", 72'(rsp_valid), 72'd1);
        tick();
        chk("sw_end", 72'({o_atomic, o_wr, rsp_valid}), 72'd0);
        chk("sw_ram", ram[8'h10], 72'h07_FFFF0000FFFF0000);

        // ---------------- back-to-back, FIFO full ----------------
        a_base   = n_astb;
        r_base   = rsp_q.size();
        t_base   = astb_times.size();
        accepted = 0;
        seen_low = 0;
        cost     = '{3, 3, 4, 5, 4};
        exp_rsp  = '{72'hA1_1111111111111111, 72'hA1_1111111111111111, 72'hA4_4444444444444444};
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: push(2'b01, 20'h00020, 64'h1111111111111111, 8'hA1);
                1: push(2'b01, 20'hFFFFF, 64'h2222222222222222, 8'hA2);
                2: push(2'b00, 20'h00020, 64'h0, 8'h0);
                3: push(2'b10, 20'h00020, 64'h4444444444444444, 8'hA4);
                4: push(2'b00, 20'h00020, 64'h0, 8'h0);
                default: push(2'b01, 20'h00021, 64'h6666666666666666, 8'hA6);
            endcase
            accepted++;
            if (!req_ready && seen_low == 0) begin
                seen_low = 1;
                chk("b2b_full_occupancy", 72'(accepted - ((n_astb - a_base) + int'(o_astb))), 72'(DEPTH));
            end
        end
        chk("b2b_saw_full", 72'(seen_low), 72'd1);
        for (int k = 0; k < 50 && !req_ready; k++) tick();
        chk("b2b_ready_on_pop", 72'(accepted - ((n_astb - a_base) + int'(o_astb))), 72'(DEPTH - 1));
        for (int k = 0; k < 200 && busy; k++) tick();
        chk("b2b_drain", 72'(busy), 72'd0);
        tick();
        chk("b2b_astb_count", 72'(astb_times.size() - t_base), 72'd6);
        if (astb_times.size() - t_base == 6)
            for (int i = 0; i < 5; i++)
                chk($sformatf("b2b_interval%0d", i),
                    72'(astb_times[t_base + i + 1] - astb_times[t_base + i]), 72'(cost[i]));
        chk("b2b_rsp_count", 72'(rsp_q.size() - r_base), 72'd3);
        if (rsp_q.size() - r_base == 3)
            for (int i = 0; i < 3; i++)
                chk($sformatf("b2b_rsp%0d", i), rsp_q[r_base + i], exp_rsp[i]);

        // ---------------- reset during RD ----------------
        push(2'b00, 20'h00003, 64'h0, 8'h0);
        tick();
        tick();
        chk("rstrd_in_rd", 72'(o_rd), 72'd1);
        r_base = rsp_q.size();
        reset  = 1'b0;
        tick();
        chk("rstrd_strobes", 72'({o_astb, o_rd, o_wr, o_atomic, rsp_valid}), 72'd0);
        chk("rstrd_busy", 72'(busy), 72'd0);
        chk("rstrd_ready_low", 72'(req_ready), 72'd0);
        reset = 1'b1;
        tick();
        chk("rstrd_ready_high", 72'(req_ready), 72'd1);
        repeat (6) tick();
        chk("rstrd_no_rsp", 72'(rsp_q.size() - r_base), 72'd0);

        // ---------------- random mix vs. scoreboard ----------------
        r_base   = rsp_q.size();
        s_astb   = n_astb;
        s_rd     = n_rd;
        s_wr     = n_wr;
        s_atomic = n_atomic;
        s_viol   = n_viol;
        n_read = 0; n_write = 0; n_swap = 0; n_rsvd = 0;
        for (int i = 0; i < 100; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = AW'($urandom_range(0, 15));
            d  = {$urandom, $urandom};
            t  = 8'($urandom);
            repeat ($urandom_range(0, 2)) tick();
            push(op, a, d, t);
            case (op)
                2'b00: begin exp_q.push_back(model[a[7:0]]); n_read++; end
                2'b01: begin model[a[7:0]] = {t, d}; n_write++; end
                2'b10: begin exp_q.push_back(model[a[7:0]]); model[a[7:0]] = {t, d}; n_swap++; end
                default: n_rsvd++;
            endcase
        end
        for (int k = 0; k < 3000 && busy; k++) tick();
        chk("rnd_drain", 72'(busy), 72'd0);
        repeat (2) tick();
        chk("rnd_rsp_count", 72'(rsp_q.size() - r_base), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && (r_base + i) < rsp_q.size(); i++)
            chk($sformatf("rnd_rsp%0d", i), rsp_q[r_base + i], exp_q[i]);
        for (int i = 0; i < 16; i++)
            chk($sformatf("rnd_mem%0d", i), ram[i], model[i]);
        chk("rnd_astb", 72'(n_astb - s_astb), 72'(100 - n_rsvd));
        chk("rnd_rd", 72'(n_rd - s_rd), 72'(n_read + n_swap));
        chk("rnd_wr", 72'(n_wr - s_wr), 72'(n_write + n_swap));
        chk("rnd_atomic", 72'(n_atomic - s_atomic), 72'(4 * n_swap));
        chk("rnd_strobe_excl", 72'(n_viol - s_viol), 72'd0);
`ifdef TBUS_MASTER_STATS_EN
        chk("stat_rd", 72'(stat_rd), 72'(n_read));
        chk("stat_wr", 72'(stat_wr), 72'(n_write));
        chk("stat_swap", 72'(stat_swap), 72'(n_swap));
        chk("stat_sum", 72'(stat_rd + stat_wr + stat_swap), 72'(100 - n_rsvd));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
